// File: rtl/alu_serial_arbiter_if.sv
// Requester-side bus of the two-port ALU serial arbiter: commands in, one-hot
// accept/response strobes and the response payload out.
interface alu_serial_arbiter_if;
  localparam int unsigned NREQ = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned OPW  = 3;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DW-1:0]  req_a;
  logic [NREQ*DW-1:0]  req_b;
  logic [NREQ*OPW-1:0] req_op;
  logic [NREQ-1:0]     rsp_valid;
  logic [DW-1:0]       rsp_c;
  logic [7:0]          rsp_ctl;
  logic [1:0]          rsp_status;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, rsp_valid, rsp_c, rsp_ctl, rsp_status
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, rsp_valid, rsp_c, rsp_ctl, rsp_status
  );
endinterface

// File: rtl/alu_serial_arbiter.sv
// Round-robin arbiter for two requesters sharing one serial ALU: sends B, A and a
// CRC-protected CTL byte as 11-bit frames, then collects the framed reply.
module alu_serial_arbiter #(
  parameter int unsigned RSP_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_serial_arbiter_if.slave  bus,
  output logic                 sin,
  input  logic                 sout,
  output logic                 busy
);
  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 3;
  localparam int unsigned TW  = $clog2(RSP_TIMEOUT + 1);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_DUT   = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_FRAME = 2'b11;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_START, RECV, RESP} state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            prio_q, prio_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [3:0]      fr_q, fr_d;
  logic [3:0]      pos_q, pos_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic [2:0]      fidx_q, fidx_d;
  logic            rx_type_q, rx_type_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic [DW-1:0]   c_q, c_d;
  logic [1:0]      req_ready_q, req_ready_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_c_q, rsp_c_d;
  logic [7:0]      rsp_ctl_q, rsp_ctl_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic            sin_d, busy_d;
  logic            win;
  logic [3:0]      crc;
  logic [7:0]      tx_byte;
  logic            tx_bit;

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_ctl    = rsp_ctl_q;
  assign bus.rsp_status = rsp_status_q;

  // CRC-4 (x^4+x+1, init 0) shifted MSB first over the whole message
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  assign crc = crc4({b_q, a_q, 1'b1, op_q});

  // Transmit bit for the current frame/position
  always_comb begin
    case (fr_q)
      4'd0:    tx_byte = b_q[31:24];
      4'd1:    tx_byte = b_q[23:16];
      4'd2:    tx_byte = b_q[15:8];
      4'd3:    tx_byte = b_q[7:0];
      4'd4:    tx_byte = a_q[31:24];
      4'd5:    tx_byte = a_q[23:16];
      4'd6:    tx_byte = a_q[15:8];
      4'd7:    tx_byte = a_q[7:0];
      default: tx_byte = {1'b0, op_q, crc};
    endcase
    if (pos_q == 4'd0)       tx_bit = 1'b0;
    else if (pos_q == 4'd1)  tx_bit = (fr_q == 4'd8);
    else if (pos_q == 4'd10) tx_bit = 1'b1;
    else                     tx_bit = tx_byte[3'(4'd9 - pos_q)];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    prio_d       = prio_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    fr_d         = fr_q;
    pos_d        = pos_q;
    idle_d       = idle_q;
    fidx_d       = fidx_q;
    rx_type_d    = rx_type_q;
    rx_byte_d    = rx_byte_q;
    c_d          = c_q;
    req_ready_d  = 2'b00;
    rsp_valid_d  = 2'b00;
    rsp_c_d      = rsp_c_q;
    rsp_ctl_d    = rsp_ctl_q;
    rsp_status_d = rsp_status_q;
    sin_d        = 1'b1;
    win          = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          win              = (&bus.req_valid) ? prio_q : bus.req_valid[1];
          grant_d          = win;
          prio_d           = ~win;
          req_ready_d[win] = 1'b1;
          a_d              = win ? bus.req_a[63:32] : bus.req_a[31:0];
          b_d              = win ? bus.req_b[63:32] : bus.req_b[31:0];
          op_d             = win ? bus.req_op[5:3]  : bus.req_op[2:0];
          fr_d             = 4'd0;
          pos_d            = 4'd0;
          state_d          = SEND;
        end
      end

      SEND: begin
        sin_d = tx_bit;
        if (pos_q == 4'd10) begin
          pos_d = 4'd0;
          if (fr_q == 4'd8) begin
            idle_d  = '0;
            fidx_d  = 3'd0;
            state_d = WAIT_START;
          end else begin
            fr_d = fr_q + 4'd1;
          end
        end else begin
          pos_d = pos_q + 4'd1;
        end
      end

      WAIT_START: begin
        if (!sout) begin
          pos_d   = 4'd0;
          state_d = RECV;
        end else if (idle_q == TW'(RSP_TIMEOUT - 1)) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_status_d         = ST_TMO;
          rsp_c_d              = '0;
          rsp_ctl_d            = '0;
          state_d              = RESP;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end

      RECV: begin
        if (pos_q == 4'd0) begin
          rx_type_d = sout;
          pos_d     = 4'd1;
        end else if (pos_q <= 4'd8) begin
          rx_byte_d = {rx_byte_q[6:0], sout};
          pos_d     = pos_q + 4'd1;
        end else begin
          // Stop bit: decide whether the frame fits the expected sequence
          idle_d = '0;
          if (!sout || (fidx_q != 3'd0 && fidx_q != 3'd4 && rx_type_q)
                    || (fidx_q == 3'd4 && !rx_type_q)) begin
            rsp_valid_d[grant_q] = 1'b1;
            rsp_status_d         = ST_FRAME;
            rsp_c_d              = '0;
            rsp_ctl_d            = '0;
            state_d              = RESP;
          end else if (fidx_q == 3'd0 && rx_type_q) begin
            rsp_valid_d[grant_q] = 1'b1;
            rsp_status_d         = ST_DUT;
            rsp_c_d              = '0;
            rsp_ctl_d            = rx_byte_q;
            state_d              = RESP;
          end else if (fidx_q == 3'd4) begin
            rsp_valid_d[grant_q] = 1'b1;
            rsp_status_d         = ST_OK;
            rsp_c_d              = c_q;
            rsp_ctl_d            = rx_byte_q;
            state_d              = RESP;
          end else begin
            c_d     = (fidx_q == 3'd0) ? {24'd0, rx_byte_q} : {c_q[23:0], rx_byte_q};
            fidx_d  = fidx_q + 3'd1;
            state_d = WAIT_START;
          end
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      prio_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      fr_q         <= '0;
      pos_q        <= '0;
      idle_q       <= '0;
      fidx_q       <= '0;
      rx_type_q    <= 1'b0;
      rx_byte_q    <= '0;
      c_q          <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_c_q      <= '0;
      rsp_ctl_q    <= '0;
      rsp_status_q <= ST_OK;
      sin          <= 1'b1;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      prio_q       <= prio_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      fr_q         <= fr_d;
      pos_q        <= pos_d;
      idle_q       <= idle_d;
      fidx_q       <= fidx_d;
      rx_type_q    <= rx_type_d;
      rx_byte_q    <= rx_byte_d;
      c_q          <= c_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_c_q      <= rsp_c_d;
      rsp_ctl_q    <= rsp_ctl_d;
      rsp_status_q <= rsp_status_d;
      sin          <= sin_d;
      busy         <= busy_d;
    end
  end
endmodule

// File: tb/tb_alu_serial_arbiter.sv
// Directed bench for alu_serial_arbiter: plays both requesters and the serial
// ALU, scoreboarding outgoing frames and responses.
module tb_alu_serial_arbiter;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst;
  logic sout;
  logic sin;
  logic busy;

  always #5 clk = ~clk;

  alu_serial_arbiter_if bus();

  alu_serial_arbiter #(.RSP_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sin  (sin),
    .sout (sout),
    .busy (busy)
  );

  typedef struct packed {
    logic [1:0]  rv;
    logic [31:0] c;
    logic [7:0]  ctl;
    logic [1:0]  st;
  } rsp_t;

  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  rsp_t        exp_q[$];
  logic [8:0]  frm_q[$];
  logic [31:0] ra[2];
  logic [31:0] rb[2];
  logic [2:0]  rop[2];

  always @(negedge clk) if (bus.rsp_valid != 2'b00) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remainder of {B,A,1,op}*x^4 modulo x^4+x+1 by long division
  function automatic logic [3:0] model_crc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  task automatic apply_req();
    bus.req_a  = {ra[1], ra[0]};
    bus.req_b  = {rb[1], rb[0]};
    bus.req_op = {rop[1], rop[0]};
  endtask

  task automatic push_frames(input int r);
    logic [31:0] w;
    w = rb[r];
    for (int k = 0; k < 4; k++) frm_q.push_back({1'b0, w[31-8*k -: 8]});
    w = ra[r];
    for (int k = 0; k < 4; k++) frm_q.push_back({1'b0, w[31-8*k -: 8]});
    frm_q.push_back({1'b1, 1'b0, rop[r], model_crc(ra[r], rb[r], rop[r])});
  endtask

  task automatic push_rsp(input logic [1:0] rv, input logic [31:0] c,
                          input logic [7:0] ctl, input logic [1:0] st);
    rsp_t e;
    e.rv = rv; e.c = c; e.ctl = ctl; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic accept(input logic [1:0] exp_grant);
    int n = 0;
    while (bus.req_ready == 2'b00 && n < 40) begin @(negedge clk); n++; end
    check("grant", 32'(bus.req_ready), 32'(exp_grant));
    check("busy_on_grant", 32'(busy), 32'd1);
    @(negedge clk);
    check("ready_one_cycle", 32'(bus.req_ready), 32'd0);
  endtask

  task automatic read_frames();
    logic [10:0] obs;
    logic [8:0]  exp;
    for (int f = 0; f < 9; f++) begin
      if (f != 0) @(negedge clk);
      obs[10] = sin;
      for (int j = 9; j >= 0; j--) begin @(negedge clk); obs[j] = sin; end
      exp = (frm_q.size() > 0) ? frm_q.pop_front() : 9'h1FF;
      check($sformatf("sin_frame%0d", f), 32'(obs), 32'({1'b0, exp, 1'b1}));
    end
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] by, input logic stp);
    @(negedge clk); sout = 1'b0;
    @(negedge clk); sout = typ;
    for (int j = 7; j >= 0; j--) begin @(negedge clk); sout = by[j]; end
    @(negedge clk); sout = stp;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); sout = 1'b1; end
  endtask

  task automatic wait_rsp(output int lat);
    rsp_t e;
    int   n = 0;
    while (bus.rsp_valid == 2'b00 && n < 200) begin @(negedge clk); n++; end
    lat = n;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : rsp_t'('1);
    check("rsp_valid", 32'(bus.rsp_valid), 32'(e.rv));
    check("rsp_status", 32'(bus.rsp_status), 32'(e.st));
    check("rsp_c", bus.rsp_c, e.c);
    if (e.st != 2'b11) check("rsp_ctl", 32'(bus.rsp_ctl), 32'(e.ctl));
    @(negedge clk);
    check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    check("busy_back_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          p0;
    logic [31:0] d;

    rst = 1'b1;
    sout = 1'b1;
    bus.req_valid = 2'b00;
    ra = '{32'd0, 32'd0}; rb = '{32'd0, 32'd0}; rop = '{3'd0, 3'd0};
    apply_req();
    repeat (3) @(negedge clk);
    check("rst_sin", 32'(sin), 32'd1);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_c", bus.rsp_c, 32'd0);
    check("rst_rsp_ctl", 32'(bus.rsp_ctl), 32'd0);
    check("rst_status", 32'(bus.rsp_status), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero operands: CTL byte must be 0x0B, reply of zeros gives OK
    check("crc_zero_model", 32'({1'b0, rop[0], model_crc(ra[0], rb[0], rop[0])}), 32'h0B);
    push_frames(0);
    bus.req_valid = 2'b01;
    accept(2'b01);
    bus.req_valid = 2'b00;
    read_frames();
    for (int k = 0; k < 4; k++) send_frame(1'b0, 8'h00, 1'b1);
    send_frame(1'b1, 8'h00, 1'b1);
    idle(1);
    push_rsp(2'b01, 32'd0, 8'h00, 2'b00);
    wait_rsp(lat);

    // Requester 1 alone, random operands, DATA frames with idle gaps
    ra[1] = $urandom; rb[1] = $urandom; rop[1] = 3'($urandom_range(0, 7));
    apply_req();
    push_frames(1);
    bus.req_valid = 2'b10;
    accept(2'b10);
    bus.req_valid = 2'b00;
    read_frames();
    d = $urandom;
    for (int k = 0; k < 4; k++) begin send_frame(1'b0, d[31-8*k -: 8], 1'b1); idle(3); end
    send_frame(1'b1, 8'h5A, 1'b1);
    idle(1);
    push_rsp(2'b10, d, 8'h5A, 2'b00);
    wait_rsp(lat);

    // Both requesters held valid: grants 0,1,0
    ra[0] = $urandom; rb[0] = $urandom; rop[0] = 3'd5;
    ra[1] = $urandom; rb[1] = $urandom; rop[1] = 3'd2;
    apply_req();
    push_frames(0);
    bus.req_valid = 2'b11;
    accept(2'b01);
    ra[0] = $urandom; rb[0] = $urandom; rop[0] = 3'd7;
    apply_req();
    read_frames();
    send_frame(1'b1, 8'hA5, 1'b1);
    idle(1);
    push_rsp(2'b01, 32'd0, 8'hA5, 2'b01);
    wait_rsp(lat);

    push_frames(1);
    accept(2'b10);
    read_frames();
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0);
    idle(1);
    push_rsp(2'b10, 32'd0, 8'h00, 2'b11);
    wait_rsp(lat);

    push_frames(0);
    accept(2'b01);
    bus.req_valid = 2'b00;
    read_frames();
    push_rsp(2'b01, 32'd0, 8'h00, 2'b10);
    wait_rsp(lat);
    check("timeout_latency", 32'(lat), 32'(TMO));
    check("timeout_sin_idle", 32'(sin), 32'd1);

    // CTL in a data slot
    push_frames(1);
    bus.req_valid = 2'b10;
    accept(2'b10);
    bus.req_valid = 2'b00;
    read_frames();
    send_frame(1'b0, 8'h01, 1'b1);
    send_frame(1'b1, 8'h02, 1'b1);
    idle(1);
    push_rsp(2'b10, 32'd0, 8'h00, 2'b11);
    wait_rsp(lat);

    // DATA in the CTL slot
    push_frames(0);
    bus.req_valid = 2'b01;
    accept(2'b01);
    bus.req_valid = 2'b00;
    read_frames();
    for (int k = 0; k < 5; k++) send_frame(1'b0, 8'(8'h30 + k), 1'b1);
    idle(1);
    push_rsp(2'b01, 32'd0, 8'h00, 2'b11);
    wait_rsp(lat);

    // Inter-frame gap longer than the timeout
    push_frames(1);
    bus.req_valid = 2'b10;
    accept(2'b10);
    bus.req_valid = 2'b00;
    read_frames();
    send_frame(1'b0, 8'hC3, 1'b1);
    push_rsp(2'b10, 32'd0, 8'h00, 2'b10);
    wait_rsp(lat);

    // Reset in the middle of SEND
    bus.req_valid = 2'b01;
    accept(2'b01);
    bus.req_valid = 2'b11;
    repeat (38) @(negedge clk);
    rst = 1'b1;
    p0 = pulses;
    @(negedge clk);
    check("midrst_sin", 32'(sin), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    push_frames(0);
    accept(2'b01);
    bus.req_valid = 2'b00;
    check("midrst_no_pulse", 32'(pulses), 32'(p0));
    read_frames();
    send_frame(1'b1, 8'h3C, 1'b1);
    idle(1);
    push_rsp(2'b01, 32'd0, 8'h3C, 2'b01);
    wait_rsp(lat);

    check("frames_drained", 32'(frm_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
